// File: rtl/rcc_frame_builder_pkg.sv
// Shared types and byte constants for the RCC frame builder.
// Frame layout: SOF, LEN_HI, LEN_LO, payload, CSUM and, optionally, EOF.
package rcc_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CSUM,
    EOF
  } frame_state_t;

  localparam logic [7:0] SOF_BYTE  = 8'hA5;
  localparam logic [7:0] EOF_BYTE  = 8'h5A;
  localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/rcc_frame_builder_if.sv
// Byte-stream input and framed valid/ready output of the RCC frame builder.
// The master side drives the serializer inputs and tx_ready; the slave side is the builder.
interface rcc_frame_if;

  logic       i_frame_start;
  logic [5:0] i_RCC_BUFFER_LENGTH;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic [7:0] o_tx_byte;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_overflow;

  modport master (
    output i_frame_start, i_RCC_BUFFER_LENGTH, i_byte, i_byte_valid, i_tx_ready,
    input  o_tx_byte, o_tx_valid, o_busy, o_frame_done, o_overflow
  );

  modport slave (
    input  i_frame_start, i_RCC_BUFFER_LENGTH, i_byte, i_byte_valid, i_tx_ready,
    output o_tx_byte, o_tx_valid, o_busy, o_frame_done, o_overflow
  );

endinterface

// File: rtl/rcc_frame_builder_fifo.sv
// Show-ahead synchronous byte FIFO with flush; a write at full is accepted only
// when a pop happens in the same cycle.
module rcc_byte_fifo #(
  parameter int FIFO_DEPTH = 16,
  localparam int FIFO_AW = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit tells full apart from empty when the indexes match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rcc_frame_builder.sv
// Wraps each serialized buffer transfer into SOF/length/payload/checksum frames.
// Define RCC_FRAME_EOF_EN to append an EOF byte (0x5A) after the checksum.
module rcc_frame_builder #(
  parameter int FIFO_DEPTH = 16
) (
  input logic        CLK,
  input logic        RESET,
  rcc_frame_if.slave bus
);
  import rcc_frame_pkg::*;

  frame_state_t state, state_n;
  logic [5:0]   len_q;
  logic [15:0]  n_bytes;
  logic [15:0]  rx_count;
  logic [15:0]  tx_count, tx_count_n;
  logic [7:0]   sum_acc, sum_n;
  logic [7:0]   tx_byte_q, tx_byte_n;
  logic         tx_valid_q, tx_valid_n;
  logic         busy_q, busy_n;
  logic         done_q, done_n;
  logic         overflow_q;
  logic         start_acc, pop, want_fetch, finish;
  logic         hs, slot_free, fetch_ok;
  logic [7:0]   fetch_data;
  logic         in_window, ovf_hit, fifo_wr, fifo_flush;
  logic [7:0]   fifo_rdata;
  logic         fifo_full, fifo_empty;

  assign n_bytes    = {8'h00, len_q, 2'b00};
  assign hs         = tx_valid_q && bus.i_tx_ready;
  assign slot_free  = !tx_valid_q || bus.i_tx_ready;
  assign fetch_ok   = overflow_q || !fifo_empty;
  assign fetch_data = overflow_q ? FILL_BYTE : fifo_rdata;

  // After an overflow the input window closes and the payload is padded with fill bytes.
  assign in_window  = busy_q && bus.i_byte_valid && (rx_count < n_bytes) && !overflow_q;
  assign ovf_hit    = in_window && fifo_full && !pop;
  assign fifo_wr    = in_window && !ovf_hit;
  assign fifo_flush = start_acc || ovf_hit;

  rcc_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (bus.i_byte),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // The state names the byte currently held in the output register.
  always_comb begin
    state_n    = state;
    tx_byte_n  = tx_byte_q;
    tx_valid_n = tx_valid_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    tx_count_n = tx_count;
    sum_n      = sum_acc;
    start_acc  = 1'b0;
    pop        = 1'b0;
    want_fetch = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_frame_start) begin
          start_acc  = 1'b1;
          state_n    = SOF;
          tx_byte_n  = SOF_BYTE;
          tx_valid_n = 1'b1;
          busy_n     = 1'b1;
          tx_count_n = '0;
          sum_n      = '0;
        end
      end
      SOF: begin
        if (hs) begin
          state_n   = LEN_HI;
          tx_byte_n = n_bytes[15:8];
          sum_n     = sum_acc + n_bytes[15:8];
        end
      end
      LEN_HI: begin
        if (hs) begin
          state_n   = LEN_LO;
          tx_byte_n = n_bytes[7:0];
          sum_n     = sum_acc + n_bytes[7:0];
        end
      end
      LEN_LO: begin
        if (hs) begin
          if (n_bytes == 16'd0) begin
            state_n   = CSUM;
            tx_byte_n = 8'h00 - sum_acc;
          end else begin
            state_n    = PAYLOAD;
            want_fetch = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (slot_free) begin
          if (tx_count == n_bytes) begin
            state_n   = CSUM;
            tx_byte_n = 8'h00 - sum_acc;
          end else begin
            want_fetch = 1'b1;
          end
        end
      end
      CSUM: begin
        if (hs) begin
`ifdef RCC_FRAME_EOF_EN
          state_n   = EOF;
          tx_byte_n = EOF_BYTE;
`else
          finish = 1'b1;
`endif
        end
      end
`ifdef RCC_FRAME_EOF_EN
      EOF: begin
        if (hs) finish = 1'b1;
      end
`endif
      default: begin
        state_n    = IDLE;
        tx_valid_n = 1'b0;
        busy_n     = 1'b0;
      end
    endcase
    // An empty FIFO mid-payload leaves a bubble until the next byte lands.
    if (want_fetch) begin
      if (fetch_ok) begin
        tx_byte_n  = fetch_data;
        tx_valid_n = 1'b1;
        pop        = !overflow_q;
        tx_count_n = tx_count + 16'd1;
        sum_n      = sum_acc + fetch_data;
      end else begin
        tx_valid_n = 1'b0;
      end
    end
    if (finish) begin
      state_n    = IDLE;
      tx_byte_n  = 8'h00;
      tx_valid_n = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      len_q      <= '0;
      rx_count   <= '0;
      tx_count   <= '0;
      sum_acc    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tx_count   <= tx_count_n;
      sum_acc    <= sum_n;
      tx_byte_q  <= tx_byte_n;
      tx_valid_q <= tx_valid_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      if (start_acc) begin
        len_q      <= bus.i_RCC_BUFFER_LENGTH;
        rx_count   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (fifo_wr) rx_count <= rx_count + 16'd1;
        if (ovf_hit) overflow_q <= 1'b1;
      end
    end
  end

  assign bus.o_tx_byte    = tx_byte_q;
  assign bus.o_tx_valid   = tx_valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_rcc_frame_builder.sv
// Directed bench for rcc_frame_builder (default build, no EOF byte): drives the
// serializer side, collects accepted output bytes and compares with hand-computed frames.
module tb_rcc_frame_builder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rcc_frame_if bus ();

  rcc_frame_builder #(.FIFO_DEPTH(16)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_count = 0;
  bit         check_hold = 1'b0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Samples the bus one time unit after the previous edge, then advances one clock.
  task automatic cycle();
    logic       stalled;
    logic [7:0] held;
    stalled = (bus.o_tx_valid === 1'b1) && (bus.i_tx_ready === 1'b0);
    held    = bus.o_tx_byte;
    if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) got.push_back(bus.o_tx_byte);
    if (bus.o_frame_done === 1'b1) done_count++;
    @(posedge clk);
    #1;
    if (check_hold && stalled) begin
      checkOutput("hold_valid", {31'd0, bus.o_tx_valid}, 32'd1);
      checkOutput("hold_byte", {24'd0, bus.o_tx_byte}, {24'd0, held});
    end
  endtask

  task automatic applyStimulus(input bit start, input logic [5:0] len, input logic [7:0] data,
                               input bit valid, input bit ready);
    bus.i_frame_start       = start;
    bus.i_RCC_BUFFER_LENGTH = len;
    bus.i_byte              = data;
    bus.i_byte_valid        = valid;
    bus.i_tx_ready          = ready;
    cycle();
  endtask

  task automatic runToDone(input string tag, input int budget, input bit rand_ready, output int cycles);
    int base;
    base   = done_count;
    cycles = 0;
    while (done_count == base && cycles < budget) begin
      applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      cycles++;
    end
    checkOutput({tag, "_done_seen"}, done_count - base, 32'd1);
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
                  {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         cyc;
    logic [7:0] sum;
    logic [7:0] fill_or;

    reset = 1'b1;
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_tx_byte",  {24'd0, bus.o_tx_byte}, 32'h00);
    checkOutput("rst_tx_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    checkOutput("rst_busy",     {31'd0, bus.o_busy}, 32'd0);
    checkOutput("rst_done",     {31'd0, bus.o_frame_done}, 32'd0);
    checkOutput("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
    reset = 1'b0;

    // Frame 1: idle bytes dropped, len=1, a second start and an extra byte ignored.
    applyStimulus(1'b0, 6'd0, 8'hAA, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'hBB, 1'b1, 1'b1);
    checkOutput("idle_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    got.delete();
    applyStimulus(1'b1, 6'd1, 8'h00, 1'b0, 1'b1);
    checkOutput("f1_sof_valid", {31'd0, bus.o_tx_valid}, 32'd1);
    checkOutput("f1_sof_byte",  {24'd0, bus.o_tx_byte}, 32'hA5);
    checkOutput("f1_busy",      {31'd0, bus.o_busy}, 32'd1);
    applyStimulus(1'b0, 6'd0, 8'h01, 1'b1, 1'b1);
    applyStimulus(1'b1, 6'd5, 8'h02, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'h03, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'h04, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'hEE, 1'b1, 1'b1);
    runToDone("f1", 50, 1'b0, cyc);
    exp_q = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    checkFrame("f1");
    checkOutput("f1_overflow", {31'd0, bus.o_overflow}, 32'd0);
    checkOutput("f1_busy_end", {31'd0, bus.o_busy}, 32'd0);
    repeat (4) applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 1'b1);
    checkOutput("f1_done_once", done_count, 32'd1);

    // Frame 2: zero-length frame, done five cycles after the start cycle.
    got.delete();
    applyStimulus(1'b1, 6'd0, 8'h00, 1'b0, 1'b1);
    runToDone("f2", 20, 1'b0, cyc);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    checkFrame("f2");
    checkOutput("f2_cycles", cyc, 32'd5);

    // Frame 3: len=2 under random ready; stalled bytes must hold.
    got.delete();
    check_hold = 1'b1;
    applyStimulus(1'b1, 6'd2, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 6'd0, 8'((i + 1) * 16), 1'b1, 1'($urandom_range(0, 1)));
    end
    runToDone("f3", 200, 1'b1, cyc);
    check_hold = 1'b0;
    exp_q = '{8'hA5, 8'h00, 8'h08, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'hB8};
    checkFrame("f3");
    checkOutput("f3_overflow", {31'd0, bus.o_overflow}, 32'd0);

    // Frame 4: 20 bytes into a 16-deep FIFO while the link is stalled.
    got.delete();
    applyStimulus(1'b1, 6'd8, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 6'd0, 8'(i), 1'b1, 1'b0);
    checkOutput("f4_overflow_set", {31'd0, bus.o_overflow}, 32'd1);
    checkOutput("f4_stalled_sof", {24'd0, bus.o_tx_byte}, 32'hA5);
    runToDone("f4", 200, 1'b0, cyc);
    checkOutput("f4_len", got.size(), 32'd36);
    if (got.size() >= 36) begin
      sum = 8'h00;
      for (int i = 1; i < 36; i++) sum += got[i];
      fill_or = 8'h00;
      for (int i = 19; i < 35; i++) fill_or |= got[i];
      checkOutput("f4_sof",      {24'd0, got[0]}, 32'hA5);
      checkOutput("f4_len_lo",   {24'd0, got[2]}, 32'h20);
      checkOutput("f4_fill",     {24'd0, fill_or}, 32'h00);
      checkOutput("f4_csum_sum", {24'd0, sum}, 32'h00);
    end
    checkOutput("f4_overflow_sticky", {31'd0, bus.o_overflow}, 32'd1);

    // Frame 5: reset during payload, then a clean frame.
    got.delete();
    applyStimulus(1'b1, 6'd4, 8'h00, 1'b0, 1'b1);
    checkOutput("f5_overflow_cleared", {31'd0, bus.o_overflow}, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 6'd0, 8'(8'h31 + i), 1'b1, 1'b1);
    checkOutput("f5_busy_mid", {31'd0, bus.o_busy}, 32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 6'd0, 8'h37, 1'b1, 1'b1);
    checkOutput("f5_rst_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    checkOutput("f5_rst_busy",  {31'd0, bus.o_busy}, 32'd0);
    reset = 1'b0;
    got.delete();
    repeat (4) applyStimulus(1'b0, 6'd0, 8'h38, 1'b1, 1'b1);
    checkOutput("f5_quiet", got.size(), 32'd0);
    applyStimulus(1'b1, 6'd1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'h05, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'h06, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'h07, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'd0, 8'h08, 1'b1, 1'b1);
    runToDone("f6", 50, 1'b0, cyc);
    exp_q = '{8'hA5, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hE2};
    checkFrame("f6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
